// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch stage.
// Contents: PC/IR width defaults, opcode constants, IR field bit positions and
// the fetch FSM state encoding.
package sisc_pkg;

  localparam int unsigned PC_W_DEF = 16;
  localparam int unsigned IR_W_DEF = 32;

  localparam logic [3:0] NOOP = 4'd0;
  localparam logic [3:0] BRA  = 4'd4;
  localparam logic [3:0] BRR  = 4'd5;
  localparam logic [3:0] BNE  = 4'd6;
  localparam logic [3:0] BNR  = 4'd7;
  localparam logic [3:0] HLT  = 4'd15;

  // Low bit of each IR field; every field except imm is 4 bits wide.
  localparam int unsigned OPCODE_LSB = 28;
  localparam int unsigned MM_LSB     = 24;
  localparam int unsigned RD_LSB     = 20;
  localparam int unsigned RS_LSB     = 16;
  localparam int unsigned RT_LSB     = 12;
  localparam int unsigned IMM_LSB    = 0;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StReq  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/sisc_fetch_unit_if.sv
// Instruction-memory req/ack bus.
// Signals: req (fetch request), addr (instruction address),
//          ack (rdata valid this cycle), rdata (instruction word).
// Modports: master = fetch unit, slave = instruction memory.
interface sisc_fetch_unit_if #(
  parameter int unsigned PC_W = 16,
  parameter int unsigned IR_W = 32
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic            ack;
  logic [IR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/sisc_branch_eval.sv
// Combinational branch resolver.
// Inputs: opcode, mm (condition mask), stat (status flags), pc (already
//         incremented), imm.
// Outputs: taken (branch condition met for a branch opcode), target (new PC).
module sisc_branch_eval
  import sisc_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic [3:0]      opcode,
  input  logic [3:0]      mm,
  input  logic [3:0]      stat,
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm,
  output logic            taken,
  output logic [PC_W-1:0] target
);

  logic            cond;
  logic [PC_W-1:0] imm_abs;
  logic [PC_W-1:0] imm_sext;

  assign cond     = |(mm & stat);
  assign imm_abs  = PC_W'(imm);
  assign imm_sext = PC_W'($signed(imm));

  always_comb begin
    taken  = 1'b0;
    target = pc;
    case (opcode)
      BRA: begin taken = cond;  target = imm_abs;         end
      BNE: begin taken = !cond; target = imm_abs;         end
      BRR: begin taken = cond;  target = pc + imm_sext;   end
      BNR: begin taken = !cond; target = pc + imm_sext;   end
      default: ;
    endcase
  end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC instruction-fetch stage: owns PC and IR, runs the imem req/ack
// handshake, decodes IR fields and applies branches on request.
// Ports: clk, rst_f (async active-low); fetch_start, br_eval, stat from the
// control FSM; imem (master side of the memory bus); decoded fields opcode,
// mm, rd, rs, rt, imm; pc; pulses fetch_done, br_taken; sticky halted,
// proto_err; br_count.
// Build option: define FETCH_BRCNT_EN to enable the saturating taken-branch
// counter on br_count; otherwise br_count is tied to zero.
module sisc_fetch_unit
  import sisc_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter int unsigned     IR_W     = IR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              fetch_start,
  input  logic              br_eval,
  input  logic [3:0]        stat,
  sisc_fetch_unit_if.master imem,
  output logic [3:0]        opcode,
  output logic [3:0]        mm,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [15:0]       imm,
  output logic [PC_W-1:0]   pc,
  output logic              fetch_done,
  output logic              br_taken,
  output logic              halted,
  output logic              proto_err,
  output logic [15:0]       br_count
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            req_q, req_d;
  logic            done_q, done_d;
  logic            taken_q, taken_d;
  logic            halted_q, halted_d;
  logic            err_q, err_d;

  logic            br_take;
  logic [PC_W-1:0] br_target;

  assign opcode = ir_q[OPCODE_LSB +: 4];
  assign mm     = ir_q[MM_LSB +: 4];
  assign rd     = ir_q[RD_LSB +: 4];
  assign rs     = ir_q[RS_LSB +: 4];
  assign rt     = ir_q[RT_LSB +: 4];
  assign imm    = ir_q[IMM_LSB +: 16];

  sisc_branch_eval #(
    .PC_W (PC_W)
  ) u_branch_eval (
    .opcode (opcode),
    .mm     (mm),
    .stat   (stat),
    .pc     (pc_q),
    .imm    (imm),
    .taken  (br_take),
    .target (br_target)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    req_d    = req_q;
    done_d   = 1'b0;
    taken_d  = 1'b0;
    halted_d = halted_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (imem.ack) err_d = 1'b1;
        if (br_eval && br_take) begin
          pc_d    = br_target;
          taken_d = 1'b1;
        end
        // The address bus is the PC register, so a same-cycle branch makes the
        // request go out at the branch target.
        if (fetch_start && !halted_q) begin
          state_d = StReq;
          req_d   = 1'b1;
        end
      end
      StReq: begin
        if (fetch_start || br_eval) err_d = 1'b1;
        if (imem.ack) begin
          ir_d    = imem.rdata;
          pc_d    = pc_q + PC_W'(1);
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
          if (imem.rdata[OPCODE_LSB +: 4] == HLT) halted_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      ir_q     <= IR_W'({NOOP, 28'd0});
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      req_q    <= req_d;
      done_q   <= done_d;
      taken_q  <= taken_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign imem.req   = req_q;
  assign imem.addr  = pc_q;
  assign pc         = pc_q;
  assign fetch_done = done_q;
  assign br_taken   = taken_q;
  assign halted     = halted_q;
  assign proto_err  = err_q;

`ifdef FETCH_BRCNT_EN
  logic [15:0] br_count_q;

  // Counts in step with the br_taken register so both update on one edge.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      br_count_q <= '0;
    end else if (taken_d && (br_count_q != 16'hFFFF)) begin
      br_count_q <= br_count_q + 16'd1;
    end
  end

  assign br_count = br_count_q;
`else
  assign br_count = '0;
`endif

endmodule

// File: tb/tb_sisc_fetch_unit.sv
module tb_sisc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        fetch_start = 1'b0;
  logic        br_eval = 1'b0;
  logic [3:0]  stat = 4'd0;
  logic [3:0]  opcode, mm, rd, rs, rt;
  logic [15:0] imm, pc, br_count;
  logic        fetch_done, br_taken, halted, proto_err;

  sisc_fetch_unit_if #(.PC_W(16), .IR_W(32)) imem ();

  sisc_fetch_unit #(.PC_W(16), .IR_W(32), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .fetch_start (fetch_start),
    .br_eval     (br_eval),
    .stat        (stat),
    .imem        (imem),
    .opcode      (opcode),
    .mm          (mm),
    .rd          (rd),
    .rs          (rs),
    .rt          (rt),
    .imm         (imm),
    .pc          (pc),
    .fetch_done  (fetch_done),
    .br_taken    (br_taken),
    .halted      (halted),
    .proto_err   (proto_err),
    .br_count    (br_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state of the fetch stage.
  logic [15:0] m_pc;
  logic [31:0] m_ir;
  logic        m_halted, m_err;
  logic [15:0] m_brcnt;

  typedef struct {
    logic [31:0] ir;
    logic [15:0] pc;
    logic        halted;
  } fexp_t;

  fexp_t       fq[$];
  logic [15:0] bq[$];
  fexp_t       mon_e;
  logic [15:0] mon_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every fetch_done / br_taken pulse must match a queued expectation.
  always @(negedge clk) begin
    if (fetch_done) begin
      if (fq.size() == 0) check("fetch_done_spurious", {31'd0, fetch_done}, 32'd0);
      else begin
        mon_e = fq.pop_front();
        check("opcode", {28'd0, opcode}, {28'd0, mon_e.ir[31:28]});
        check("mm", {28'd0, mm}, {28'd0, mon_e.ir[27:24]});
        check("rd", {28'd0, rd}, {28'd0, mon_e.ir[23:20]});
        check("rs", {28'd0, rs}, {28'd0, mon_e.ir[19:16]});
        check("rt", {28'd0, rt}, {28'd0, mon_e.ir[15:12]});
        check("imm", {16'd0, imm}, {16'd0, mon_e.ir[15:0]});
        check("fetch_pc", {16'd0, pc}, {16'd0, mon_e.pc});
        check("halted", {31'd0, halted}, {31'd0, mon_e.halted});
      end
    end
    if (br_taken) begin
      if (bq.size() == 0) check("br_taken_spurious", {31'd0, br_taken}, 32'd0);
      else begin
        mon_t = bq.pop_front();
        check("br_target", {16'd0, pc}, {16'd0, mon_t});
      end
    end
  end

  // Branch rule: condition from mask & flags, absolute or next-PC-relative target.
  task automatic model_branch(input logic [3:0] st);
    int op, mmv, immv, off, tgt;
    bit cond, tk;
    op   = int'(m_ir[31:28]);
    mmv  = int'(m_ir[27:24]);
    immv = int'(m_ir[15:0]);
    cond = (mmv & int'(st)) != 0;
    tk   = (op == 4 || op == 5) ? cond : (op == 6 || op == 7) ? !cond : 1'b0;
    if (op == 4 || op == 6) tgt = immv;
    else begin
      off = (immv >= 32768) ? immv - 65536 : immv;
      tgt = (int'(m_pc) + off) & 32'hFFFF;
    end
    if (tk) begin
      m_pc = tgt[15:0];
      bq.push_back(m_pc);
`ifdef FETCH_BRCNT_EN
      if (m_brcnt != 16'hFFFF) m_brcnt = m_brcnt + 16'd1;
`endif
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_ir = 32'd0; m_halted = 1'b0; m_err = 1'b0; m_brcnt = 16'd0;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_req"}, {31'd0, imem.req}, 32'd0);
    check({tag, "_pc"}, {16'd0, pc}, {16'd0, m_pc});
    check({tag, "_opcode"}, {28'd0, opcode}, {28'd0, m_ir[31:28]});
    check({tag, "_halted"}, {31'd0, halted}, {31'd0, m_halted});
    check({tag, "_proto_err"}, {31'd0, proto_err}, {31'd0, m_err});
    check({tag, "_br_count"}, {16'd0, br_count}, {16'd0, m_brcnt});
  endtask

  // poke: 0 none, 1 fetch_start during REQ, 2 br_eval during REQ (needs waits>=1).
  task automatic do_fetch(input logic [31:0] word, input int waits, input bit with_br,
                          input logic [3:0] st, input int poke);
    fetch_start = 1'b1;
    if (with_br) begin
      br_eval = 1'b1;
      stat    = st;
      model_branch(st);
    end
    tick();
    fetch_start = 1'b0;
    br_eval     = 1'b0;
    if (m_halted) begin
      check("halt_no_req", {31'd0, imem.req}, 32'd0);
      return;
    end
    check("req_rise", {31'd0, imem.req}, 32'd1);
    check("req_addr", {16'd0, imem.addr}, {16'd0, m_pc});
    for (int i = 0; i < waits; i++) begin
      if (i == 0 && poke == 1) begin fetch_start = 1'b1; m_err = 1'b1; end
      if (i == 0 && poke == 2) begin br_eval = 1'b1; stat = 4'($urandom); m_err = 1'b1; end
      tick();
      fetch_start = 1'b0;
      br_eval     = 1'b0;
      check("req_hold", {31'd0, imem.req}, 32'd1);
      check("addr_hold", {16'd0, imem.addr}, {16'd0, m_pc});
    end
    imem.ack   = 1'b1;
    imem.rdata = word;
    m_ir = word;
    m_pc = m_pc + 16'd1;
    if (word[31:28] == 4'hF) m_halted = 1'b1;
    fq.push_back('{word, m_pc, m_halted});
    tick();
    imem.ack   = 1'b0;
    imem.rdata = $urandom;
    check("req_fall", {31'd0, imem.req}, 32'd0);
    check("proto_err", {31'd0, proto_err}, {31'd0, m_err});
  endtask

  task automatic do_branch(input logic [3:0] st);
    stat    = st;
    br_eval = 1'b1;
    model_branch(st);
    tick();
    br_eval = 1'b0;
    check("br_pc", {16'd0, pc}, {16'd0, m_pc});
    check("br_count", {16'd0, br_count}, {16'd0, m_brcnt});
    check("br_proto_err", {31'd0, proto_err}, {31'd0, m_err});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_f = 1'b0;
    #1;
    model_reset();
    check_idle_state("reset");
    @(negedge clk);
    rst_f = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 3) == 0) w[31:28] = 4'($urandom_range(0, 14));
    else w[31:28] = 4'($urandom_range(4, 7));
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    imem.ack   = 1'b0;
    imem.rdata = 32'd0;
    model_reset();
    #12;
    check_idle_state("por");
    check("por_fetch_done", {31'd0, fetch_done}, 32'd0);
    check("por_br_taken", {31'd0, br_taken}, 32'd0);
    @(negedge clk);
    rst_f = 1'b1;
    tick();

    // First fetch with three wait states.
    do_fetch(32'h1123_4567, 3, 1'b0, 4'd0, 0);

    // BRA absolute: taken, then not taken.
    do_fetch({4'd4, 4'b0010, 8'h00, 16'h0040}, 0, 1'b0, 4'd0, 0);
    do_branch(4'b0010);
    do_branch(4'b0001);

    // BNR relative from pc=5 with offset -2.
    do_fetch({4'd4, 4'hF, 8'h00, 16'h0004}, 1, 1'b0, 4'd0, 0);
    do_branch(4'hF);
    do_fetch({4'd7, 4'b0001, 8'h00, 16'hFFFE}, 0, 1'b0, 4'd0, 0);
    check("bnr_setup_pc", {16'd0, pc}, 32'h0005);
    do_branch(4'd0);

    // PC wrap from 16'hFFFF.
    do_fetch({4'd4, 4'hF, 8'h00, 16'hFFFF}, 0, 1'b0, 4'd0, 0);
    do_branch(4'h8);
    do_fetch(32'h1000_0000, 2, 1'b0, 4'd0, 0);
    check("wrap_pc", {16'd0, pc}, 32'h0000);

    // Branch and fetch in the same cycle: request goes to the target.
    do_fetch({4'd4, 4'hF, 8'h00, 16'h0100}, 0, 1'b0, 4'd0, 0);
    do_fetch(32'h2345_6789, 1, 1'b1, 4'hF, 0);

    for (int n = 0; n < 80; n++) begin
      do_fetch(rand_word(), $urandom_range(0, 3), 1'b0, 4'd0, 0);
      if ($urandom_range(0, 1) == 1) do_branch(4'($urandom));
      if ($urandom_range(0, 3) == 0)
        do_fetch(rand_word(), $urandom_range(0, 2), 1'b1, 4'($urandom), 0);
    end

    // Protocol violations; in-flight fetches must still complete.
    imem.ack   = 1'b1;
    imem.rdata = 32'h7777_7777;
    m_err      = 1'b1;
    tick();
    imem.ack = 1'b0;
    check_idle_state("spurious_ack");
    do_fetch(rand_word(), 2, 1'b0, 4'd0, 1);
    do_fetch(rand_word(), 2, 1'b0, 4'd0, 2);

    // HLT then further fetch attempts.
    do_fetch(32'hF000_0000, 1, 1'b0, 4'd0, 0);
    do_fetch(32'h1111_1111, 0, 1'b0, 4'd0, 0);
    tick();
    check_idle_state("halted");

    // Reset while a request is outstanding; late ack arrives during reset.
    apply_reset();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("midreq_req", {31'd0, imem.req}, 32'd1);
    @(negedge clk);
    rst_f = 1'b0;
    #1;
    check("midreq_req_drop", {31'd0, imem.req}, 32'd0);
    imem.ack   = 1'b1;
    imem.rdata = 32'h1234_5678;
    tick();
    imem.ack = 1'b0;
    @(negedge clk);
    rst_f = 1'b1;
    tick();
    tick();
    check_idle_state("midreq");

    // Three taken branches for the branch counter.
    do_fetch({4'd4, 4'hF, 8'h00, 16'h0010}, 0, 1'b0, 4'd0, 0);
    for (int k = 0; k < 3; k++) do_branch(4'b0001);
`ifdef FETCH_BRCNT_EN
    check("br_count_three", {16'd0, br_count}, 32'd3);
`endif

    tick();
    tick();
    check("fetch_queue_drained", fq.size(), 32'd0);
    check("branch_queue_drained", bq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
